// File: rtl/alu_result_stage.sv
// Write-back stage behind the ALU: queues {result, flags, opcode} in a small FIFO with a
// valid/ready consumer port, keeps sticky flags and an accept counter, and checks flag sanity.
module alu_result_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     inValid,
   output logic                     inReady,
   input  logic [WIDTH-1:0]         inW,
   input  logic                     inZer,
   input  logic                     inNeg,
   input  logic [2:0]               inOpc,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [WIDTH-1:0]         outW,
   output logic                     outZer,
   output logic                     outNeg,
   output logic [2:0]               outOpc,
   output logic                     stickyZer,
   output logic                     stickyNeg,
   output logic                     flagErr,
   input  logic                     clrSticky,
   output logic [7:0]               acceptCount,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] w;
      logic             zer;
      logic             neg;
      logic [2:0]       opc;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic            mismatch;

   // Ready/valid depend only on registered occupancy, so outReady never reaches inReady.
   assign inReady  = (level != LW'(DEPTH));
   assign outValid = (level != '0);
   assign push     = inValid && inReady;
   assign pop      = outValid && outReady;
   assign mismatch = (inZer != (inW == '0)) || (inNeg != inW[WIDTH-1]);

   assign head   = mem[rd_ptr];
   assign outW   = head.w;
   assign outZer = head.zer;
   assign outNeg = head.neg;
   assign outOpc = head.opc;

   // NOTE: storage is reset too, so the head outputs read as zero straight out of reset;
   // this costs a reset net per storage flop, which is acceptable at this tiny depth.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
      end else if (push) begin
         mem[wr_ptr] <= '{w: inW, zer: inZer, neg: inNeg, opc: inOpc};
         wr_ptr      <= wr_ptr + AW'(1);
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // A set from this cycle's push overrides a simultaneous clear.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stickyZer   <= 1'b0;
         stickyNeg   <= 1'b0;
         flagErr     <= 1'b0;
         acceptCount <= '0;
      end else begin
         stickyZer <= (stickyZer && !clrSticky) || (push && inZer);
         stickyNeg <= (stickyNeg && !clrSticky) || (push && inNeg);
         flagErr   <= (flagErr   && !clrSticky) || (push && mismatch);
         if (push) acceptCount <= acceptCount + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, pass-through, backpressure, sticky flags,
// asynchronous mid-run reset and counter wrap with an in-order data check.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rstN;
   logic        inValid, inReady, inZer, inNeg;
   logic [15:0] inW;
   logic [2:0]  inOpc;
   logic        outValid, outReady, outZer, outNeg;
   logic [15:0] outW;
   logic [2:0]  outOpc;
   logic        stickyZer, stickyNeg, flagErr, clrSticky;
   logic [7:0]  acceptCount;
   logic [2:0]  level;

   int total = 0;
   int bad   = 0;

   alu_result_stage #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rstN(rstN),
      .inValid(inValid), .inReady(inReady), .inW(inW), .inZer(inZer), .inNeg(inNeg), .inOpc(inOpc),
      .outValid(outValid), .outReady(outReady), .outW(outW), .outZer(outZer), .outNeg(outNeg),
      .outOpc(outOpc), .stickyZer(stickyZer), .stickyNeg(stickyNeg), .flagErr(flagErr),
      .clrSticky(clrSticky), .acceptCount(acceptCount), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle; inputs are changed right after this point.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [15:0] w, input logic z, input logic n,
                         input logic [2:0] o);
      inValid = v; inW = w; inZer = z; inNeg = n; inOpc = o;
   endtask

   initial begin
      logic [15:0] exp_q [$];
      logic [15:0] pop_order [5];
      int          pops;

      rstN = 1'b0; outReady = 1'b0; clrSticky = 1'b0;
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      #12 rstN = 1'b1;
      cyc();

      // reset state
      check("rst_level",    32'(level),       32'd0);
      check("rst_inReady",  32'(inReady),     32'd1);
      check("rst_outValid", 32'(outValid),    32'd0);
      check("rst_count",    32'(acceptCount), 32'd0);
      check("rst_outW",     32'(outW),        32'd0);
      check("rst_sticky",   32'({stickyZer, stickyNeg, flagErr}), 32'd0);

      // single pass-through with held output
      set_in(1'b1, 16'h8001, 1'b0, 1'b1, 3'd3);
      cyc();
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      check("pt_valid",   32'(outValid),  32'd1);
      check("pt_outW",    32'(outW),      32'h8001);
      check("pt_outNeg",  32'(outNeg),    32'd1);
      check("pt_outZer",  32'(outZer),    32'd0);
      check("pt_outOpc",  32'(outOpc),    32'd3);
      check("pt_stkNeg",  32'(stickyNeg), 32'd1);
      check("pt_flagErr", 32'(flagErr),   32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("pt_hold", 32'({outValid, outW, outOpc}), 32'({1'b1, 16'h8001, 3'd3}));
      end
      outReady = 1'b1;
      cyc();
      outReady = 1'b0;
      check("pt_drain_valid", 32'(outValid), 32'd0);
      check("pt_drain_level", 32'(level),    32'd0);

      // fill to full, then backpressure
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b1, 16'(i), 1'b0, 1'b0, 3'(i));
         cyc();
      end
      set_in(1'b1, 16'd5, 1'b0, 1'b0, 3'd5);
      check("full_level",   32'(level),   32'd4);
      check("full_inReady", 32'(inReady), 32'd0);
      cyc();
      check("full_hold_level", 32'(level),       32'd4);
      check("full_no_accept",  32'(acceptCount), 32'd5);
      pop_order = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
      outReady = 1'b1;
      check("pop_order0", 32'(outW), 32'(pop_order[0]));
      cyc();
      check("full_pop_nopush_level", 32'(level),       32'd3);
      check("full_pop_nopush_count", 32'(acceptCount), 32'd5);
      check("pop_order1", 32'(outW), 32'(pop_order[1]));
      cyc();
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      check("push5_count", 32'(acceptCount), 32'd6);
      check("push5_level", 32'(level),       32'd3);
      for (int i = 2; i < 5; i++) begin
         check("pop_order", 32'(outW), 32'(pop_order[i]));
         cyc();
      end
      check("drain_level", 32'(level), 32'd0);

      // sticky flags and flag consistency (outReady stays high)
      set_in(1'b1, 16'h0000, 1'b1, 1'b0, 3'd1);
      cyc();
      check("stk_zer_set",  32'(stickyZer), 32'd1);
      check("stk_err_none", 32'(flagErr),   32'd0);
      set_in(1'b1, 16'h0005, 1'b1, 1'b0, 3'd2);
      cyc();
      check("stk_err_set", 32'(flagErr), 32'd1);
      set_in(1'b1, 16'hFFFF, 1'b0, 1'b1, 3'd4);
      clrSticky = 1'b1;
      cyc();
      clrSticky = 1'b0;
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      check("clr_stkZer", 32'(stickyZer), 32'd0);
      check("clr_flagErr", 32'(flagErr),  32'd0);
      check("clr_setwins_stkNeg", 32'(stickyNeg), 32'd1);
      check("clr_count", 32'(acceptCount), 32'd9);
      clrSticky = 1'b1;
      cyc();
      clrSticky = 1'b0;
      check("clr_only_stkNeg", 32'(stickyNeg), 32'd0);
      check("clr_only_count",  32'(acceptCount), 32'd9);

      // asynchronous reset with three entries queued
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 16'h8000 + 16'(i), 1'b0, 1'b1, 3'(i));
         cyc();
      end
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      check("pre_arst_level", 32'(level), 32'd3);
      #2 rstN = 1'b0;
      #1;
      check("arst_level",    32'(level),       32'd0);
      check("arst_inReady",  32'(inReady),     32'd1);
      check("arst_outValid", 32'(outValid),    32'd0);
      check("arst_count",    32'(acceptCount), 32'd0);
      check("arst_out",      32'({outW, outZer, outNeg, outOpc}), 32'd0);
      check("arst_sticky",   32'({stickyZer, stickyNeg}), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      cyc();

      // 257 back-to-back pushes with streaming pops
      outReady = 1'b1;
      pops = 0;
      for (int i = 0; i < 257; i++) begin
         set_in(1'b1, 16'(i), (i == 0), 1'b0, 3'(i));
         if (outValid) begin
            check("wrap_data", 32'(outW), 32'(exp_q.pop_front()));
            pops++;
         end
         exp_q.push_back(16'(i));
         cyc();
      end
      set_in(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      if (outValid) begin
         check("wrap_data", 32'(outW), 32'(exp_q.pop_front()));
         pops++;
      end
      cyc();
      check("wrap_count",   32'(acceptCount), 32'd1);
      check("wrap_level",   32'(level),       32'd0);
      check("wrap_pops",    32'(pops),        32'd257);
      check("wrap_flagErr", 32'(flagErr),     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
